// File: rtl/mmio_pkg.sv
// Shared MMIO address map, UART RX STATUS bit layout and receive FSM state encoding.
// The UART_RX_PARITY_EN build option is consumed by uart_rx_mmio, not here.
package mmio_pkg;

  localparam logic [31:0] TX_ADDR     = 32'h2000_0000;
  localparam logic [31:0] RXDATA_ADDR = 32'h2000_0004;
  localparam logic [31:0] STATUS_ADDR = 32'h2000_0008;

  localparam int ST_NONEMPTY  = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_OVERRUN   = 2;
  localparam int ST_FRAME     = 3;
  localparam int ST_PARITY    = 4;
  localparam int ST_COUNT_LSB = 8;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  typedef enum logic [2:0] {
    RX_IDLE   = S_IDLE,
    RX_START  = S_START,
    RX_DATA   = S_DATA,
    RX_PARITY = S_PARITY,
    RX_STOP   = S_STOP
  } rx_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous byte FIFO with first-word-fall-through read data, full/empty and occupancy count.
// A push into a full FIFO is accepted only when a pop happens on the same edge.
module uart_rx_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [7:0]               wdata_i,
  output logic [7:0]               rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata_i;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (do_push && !do_pop) begin
      count_d = count_q + (AW+1)'(1);
    end else if (do_pop && !do_push) begin
      count_d = count_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/uart_rx_mmio.sv
// Memory-mapped UART receiver: 8N1 deserialiser into a byte FIFO with RXDATA/STATUS registers.
// Define UART_RX_PARITY_EN for 8E1 framing with a parity check and sticky parity_err flag.
//
// state    | meaning
// IDLE     | line idle, waiting for a synchronised falling edge
// START    | counting to mid start bit; a high sample there is a false start
// DATA     | sampling 8 data bits LSB first, one per bit period
// PARITY   | sampling the even-parity bit (parity build only)
// STOP     | sampling the stop bit, then push or flag an error
module uart_rx_mmio
  import mmio_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx,
  input  logic        mem_read,
  input  logic [31:0] alu_result,
  output logic [31:0] rd_data,
  output logic        rd_hit,
  output logic        rx_irq
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT/2 - 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);

  logic [1:0]    sync_q, sync_d;
  logic          line_prev_q, line_prev_d;
  rx_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          overrun_q, overrun_d;
  logic          frame_q, frame_d;
  logic [31:0]   rd_data_q, rd_data_d;
  logic          rd_hit_q, rd_hit_d;
`ifdef UART_RX_PARITY_EN
  logic          par_bad_q, par_bad_d;
  logic          par_err_q, par_err_d;
`endif

  logic          line, cnt_zero;
  logic          push, pop, hit_rx, hit_st;
  logic          ev_over, ev_frame, ev_par;
  logic [7:0]    fifo_rdata;
  logic          fifo_full, fifo_empty;
  logic [AW:0]   fifo_count;
  logic [31:0]   status_word;
  logic          unused_addr_bits;

  assign unused_addr_bits = ^alu_result[1:0];

  assign line     = sync_q[1];
  assign cnt_zero = (cnt_q == '0);
  assign hit_rx   = mem_read && (alu_result[31:2] == RXDATA_ADDR[31:2]);
  assign hit_st   = mem_read && (alu_result[31:2] == STATUS_ADDR[31:2]);
  assign pop      = hit_rx && !fifo_empty;

  uart_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (shift_q),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    sync_d      = {sync_q[0], rx};
    line_prev_d = line;
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    push        = 1'b0;
    ev_over     = 1'b0;
    ev_frame    = 1'b0;
    ev_par      = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d   = par_bad_q;
`endif
    case (state_q)
      RX_IDLE: begin
        // Edge-triggered start keeps a held-low line from re-arming after a break.
        if (line_prev_q && !line) begin
          state_d = RX_START;
          cnt_d   = HALF_LOAD;
        end
      end
      RX_START: begin
        if (!cnt_zero) begin
          cnt_d = cnt_q - CW'(1);
        end else if (!line) begin
          state_d = RX_DATA;
          cnt_d   = FULL_LOAD;
          bit_d   = 3'd0;
        end else begin
          state_d = RX_IDLE;
        end
      end
      RX_DATA: begin
        if (!cnt_zero) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          shift_d = {line, shift_q[7:1]};
          cnt_d   = FULL_LOAD;
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = RX_PARITY;
`else
            state_d = RX_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      RX_PARITY: begin
        if (!cnt_zero) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          par_bad_d = line ^ (^shift_q);
          cnt_d     = FULL_LOAD;
          state_d   = RX_STOP;
        end
      end
`endif
      RX_STOP: begin
        if (!cnt_zero) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          state_d = RX_IDLE;
          if (!line) begin
            ev_frame = 1'b1;
`ifdef UART_RX_PARITY_EN
          end else if (par_bad_q) begin
            ev_par = 1'b1;
`endif
          end else if (fifo_full && !pop) begin
            ev_over = 1'b1;
          end else begin
            push = 1'b1;
          end
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_comb begin
    status_word                          = '0;
    status_word[ST_NONEMPTY]             = !fifo_empty;
    status_word[ST_FULL]                 = fifo_full;
    status_word[ST_OVERRUN]              = overrun_q;
    status_word[ST_FRAME]                = frame_q;
`ifdef UART_RX_PARITY_EN
    status_word[ST_PARITY]               = par_err_q;
`endif
    status_word[ST_COUNT_LSB +: 8]       = 8'(fifo_count);

    rd_data_d = rd_data_q;
    rd_hit_d  = 1'b0;
    if (hit_rx) begin
      rd_hit_d  = 1'b1;
      rd_data_d = fifo_empty ? 32'h0 : {24'h0, fifo_rdata};
    end else if (hit_st) begin
      rd_hit_d  = 1'b1;
      rd_data_d = status_word;
    end

    // A new error event on the clearing edge wins over the clear.
    overrun_d = (overrun_q && !hit_st) || ev_over;
    frame_d   = (frame_q && !hit_st) || ev_frame;
`ifdef UART_RX_PARITY_EN
    par_err_d = (par_err_q && !hit_st) || ev_par;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q      <= 2'b11;
      line_prev_q <= 1'b1;
      state_q     <= RX_IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      overrun_q   <= 1'b0;
      frame_q     <= 1'b0;
      rd_data_q   <= '0;
      rd_hit_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q   <= 1'b0;
      par_err_q   <= 1'b0;
`endif
    end else begin
      sync_q      <= sync_d;
      line_prev_q <= line_prev_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      overrun_q   <= overrun_d;
      frame_q     <= frame_d;
      rd_data_q   <= rd_data_d;
      rd_hit_q    <= rd_hit_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q   <= par_bad_d;
      par_err_q   <= par_err_d;
`endif
    end
  end

  assign rd_data = rd_data_q;
  assign rd_hit  = rd_hit_q;
  assign rx_irq  = !fifo_empty;

endmodule

// File: doc/uart_rx_mmio.md
# uart_rx_mmio

Memory-mapped UART receiver: the inbound counterpart of the console output port at 0x2000_0000. It deserialises an 8N1 serial line into a byte FIFO and exposes data and status registers to the core's load path. It sits beside the data memory in the MEM stage and shares its address/read-strobe inputs. The core polls it, or uses `rx_irq`, to read console input.

## Interface
- `CLKS_PER_BIT`, 16: clock cycles per serial bit. Must be ≥4 and even.
- `FIFO_DEPTH`, 8: receive FIFO entries. Power of two, 2..128.
- `clk` input 1: sole clock, rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `rx` input 1: asynchronous serial input, idles high.
- `mem_read` input 1: load strobe from the core, valid in the request cycle.
- `alu_result` input 32: load address.
- `rd_data` output 32: registered read data.
- `rd_hit` output 1: registered; high when `rd_data` holds a response from this block.
- `rx_irq` output 1: FIFO non-empty.

## Operation
- Register map:
  - 0x2000_0004 RXDATA: read pops the FIFO and returns {24'b0, byte}. Reading while empty returns 0 and has no side effect.
  - 0x2000_0008 STATUS:
    - bit0: non-empty
    - bit1: full
    - bit2: overrun (sticky)
    - bit3: frame_err (sticky)
    - bit4: parity_err (sticky)
    - bits[15:8]: FIFO count
    - all other bits 0
  - A STATUS read clears bits 2–4 on the response edge.
- `rx` passes through a 2-flop synchroniser before any use. Both flops reset to 1.
- Receive FSM states: IDLE, START, DATA, (PARITY), STOP.
  - IDLE: on a synchronised falling edge, go to START and load the bit counter with CLKS_PER_BIT/2−1.
  - START: at counter expiry, sample the line. If low, go to DATA with counter CLKS_PER_BIT−1. If high, it was a false start: return to IDLE.
  - DATA: sample every CLKS_PER_BIT cycles, 8 samples, LSB first, shifted into the shift register. Then go to PARITY if enabled, else STOP.
  - STOP: sample once.
    - Sample 1, no parity error, FIFO not full: push the byte.
    - Sample 1, FIFO full: drop the byte and set overrun.
    - Sample 0: drop the byte and set frame_err.
    - Return to IDLE in all cases.
- A break condition (line held low) produces one frame_err per frame. The FSM waits in IDLE until the line returns high before it re-arms.
- Only bits [31:2] of `alu_result` are decoded. Unmapped addresses give `rd_hit`=0 and `rd_data` unchanged.

## Timing
- Reset values:
  - `rd_data`=0, `rd_hit`=0, `rx_irq`=0.
  - FSM in IDLE, FIFO empty, flags 0, shift register 0.
- Reset mid-frame abandons the frame; no partial byte is pushed.
- Read latency: request in cycle N; `rd_data`/`rd_hit` valid after the rising edge ending N. The FIFO pop and the sticky-flag clear occur on that same edge.
- Push latency: the byte enters the FIFO on the edge of the mid-stop sample. Count and `rx_irq` update on that edge.
- Simultaneous push and pop: both occur, count unchanged.
  - Pop on a full FIFO plus a completing byte: no overrun.
- Simultaneous STATUS-read clear and a new error event: the new event wins and the flag stays set.
- Pointers are log2(FIFO_DEPTH) bits and wrap naturally. Count is log2(FIFO_DEPTH)+1 bits, zero-extended into bits[15:8].

## Configuration
- `UART_RX_PARITY_EN`
  - Defined: 8E1 framing. The PARITY state samples one even-parity bit after the data bits. On a mismatch, the byte is not pushed and parity_err is set.
  - Undefined: 8N1 framing. The PARITY state and its logic are absent, and STATUS bit4 reads 0.

## Structure
- Package `mmio_pkg` holds:
  - the RXDATA/STATUS address constants (alongside the existing 0x2000_0000 TX address);
  - the STATUS bit-index constants;
  - the FSM state enum.
- Sub-module `uart_rx_fifo` provides a synchronous FIFO with push/pop, full/empty and count. It uses the same `clk`/`rst_n`.

## Test plan
- Send 0x55 at CLKS_PER_BIT=16. Read STATUS, then RXDATA, then STATUS:
  - first STATUS = 0x0000_0101;
  - RXDATA = 0x0000_0055, `rd_hit`=1 one cycle after the request;
  - final STATUS = 0x0000_0000, `rx_irq`=0.
- Send a 0.5-bit low glitch (8 cycles), then idle → FSM returns to IDLE, FIFO empty, no flags.
- Send 9 bytes 0x01..0x09 with FIFO_DEPTH=8 and no reads:
  - STATUS = 0x0000_0807 (full + overrun);
  - RXDATA reads return 0x01..0x08 in order;
  - then a STATUS read returns 0x0000_0000.
- Send 0xA3 with the stop bit forced 0 → STATUS = 0x0000_0008, FIFO empty. The next STATUS read returns 0.
- Assert `rst_n`=0 for 1 cycle mid-DATA of byte 0xFF, then send 0x3C → only 0x3C is received, count 1.
- With `UART_RX_PARITY_EN`:
  - send 0x07 with parity 1 → accepted;
  - send 0x07 with parity 0 → dropped, STATUS bit4 set.
